bram_tdp_ctrl: RTL and testbench
================================

Name: bram_tdp_ctrl

Overview:
- Parametrised true dual-port block RAM, the successor to the fixed 16x32 CNN buffer RAM.
- Width and depth are generic, and reads carry a valid strobe.
- Same-cycle collision policy is deterministic.
- After reset, an init sweep clears the memory, so CNN layer buffers start from a known value without the host writing every word.

Parameters:
- DATA_W, 16, word width in bits.
- ADDR_W, 5, address width in bits.
- DEPTH, 32, number of words; must satisfy DEPTH <= 2**ADDR_W.
- INIT_ON_RESET, 1, when 1 the init sweep runs after reset; when 0 the block is ready immediately and contents are undefined.
- INIT_VALUE, 0, word written to every address during the sweep.

Ports:
- clock  in  1  single clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- init_busy  out  1  high while the init sweep runs; port requests are ignored while high.
- data_a  in  DATA_W  port A write data.
- address_a  in  ADDR_W  port A address.
- wren_a  in  1  port A write enable.
- rden_a  in  1  port A read enable.
- q_a  out  DATA_W  port A read data, registered.
- qvalid_a  out  1  one-cycle strobe marking q_a as new.
- data_b, address_b, wren_b, rden_b, q_b, qvalid_b: identical to port A, for port B.

Behaviour:
- Reset (asynchronous):
  - q_a, q_b = 0; qvalid_a, qvalid_b = 0; init counter = 0.
  - State = INIT if INIT_ON_RESET, else READY.
  - init_busy = INIT_ON_RESET.
  - The memory array itself is not reset.
- FSM states:
  - INIT: write INIT_VALUE to counter address and increment counter each cycle.
  - Counter == DEPTH-1 written -> READY on the next edge; init_busy falls with that transition.
  - The sweep takes exactly DEPTH cycles after reset release.
  - In INIT, wren and rden on both ports are dropped; q holds and qvalid stays 0.
  - READY: normal operation; the block never returns to INIT except through reset.
- Reset asserted mid-sweep: the sweep aborts and restarts at address 0 after release.
- Read latency is 1:
  - rden_x sampled high at edge N -> q_x updated and qvalid_x = 1 after edge N.
  - qvalid_x clears after the next edge unless rden_x is high again.
  - Back-to-back reads stream one word per cycle.
  - With rden_x low, q_x holds its last value.
- Same-port wren and rden in the same cycle: write-first; q_x returns data_x.
- Cross-port read of an address written in the same cycle: the reader gets the OLD word; the new word is visible from the next cycle.
- Both ports write the same address in the same cycle: port A wins; port B's write is discarded.
- Address >= DEPTH (only possible when DEPTH < 2**ADDR_W):
  - Writes are ignored.
  - Reads return 0 with qvalid still pulsed.
- No arithmetic beyond the init counter, which is ADDR_W bits wide and never wraps past DEPTH-1.

Optional Feature:
- Macro: BRAM_COLLISION_DET_EN.
- When defined:
  - Adds output port collision (out, 1 bit), reset value 0.
  - collision is registered and pulses 1 for one cycle after any READY cycle in which both ports address the same location and at least one wren is high.
  - It does not pulse during INIT.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package bram_pkg holds:
  - State enum bram_state_t {ST_INIT, ST_READY}.
  - The write-priority constant (PORT_A_WINS) and the read-during-write mode constants.
- One sub-module, bram_init_ctrl, contains the FSM, the init counter and init_busy, and outputs the sweep write enable and address.
- The top level holds the memory array, the port muxing and the read registers.

Test Plan (DATA_W=16, ADDR_W=5, DEPTH=32, INIT_VALUE=0):
- Release reset -> init_busy high for exactly 32 cycles, then low; reading addresses 0..31 returns 0x0000 with qvalid high one cycle after each rden.
- Write A[3]=0xBEEF, then rden_a at addr 3 -> q_a=0xBEEF and qvalid_a=1 one cycle later; with rden_a held low, q_a holds 0xBEEF and qvalid_a=0.
- A writes 0x1234 to addr 7 while B reads addr 7 in the same cycle (old 0xBEEF) -> q_b=0xBEEF; B reads addr 7 next cycle -> 0x1234.
- A writes 0xAAAA and B writes 0x5555 to addr 9 in the same cycle -> a later read of addr 9 returns 0xAAAA; with BRAM_COLLISION_DET_EN, collision=1 for exactly one cycle.
- Same-port wren_a and rden_a at addr 2 with data 0x0F0F -> q_a=0x0F0F next cycle (write-first).
- Assert reset at sweep counter 15, hold 2 cycles, release -> init_busy high for a full 32 cycles; rden during the sweep yields no qvalid.

Source files
------------

// File: rtl/bram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_pkg
// Description : Shared types and constants for the bram_tdp_ctrl block:
//               controller state encoding, write-priority and
//               read-during-write policy constants.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_pkg;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } bram_state_t;

    // When both ports write the same word in one cycle, port A's data is kept.
    localparam logic PORT_A_WINS = 1'b1;

    // Read-during-write behaviour.
    localparam logic [0:0] RDW_OLD_DATA = 1'b0;   // reader sees the word before the write
    localparam logic [0:0] RDW_NEW_DATA = 1'b1;   // reader sees the word being written

    // A port reading and writing the same cycle returns its own write data.
    // A cross-port read always returns the old word; that needs no constant
    // because it follows naturally from the registered memory read.
    localparam logic [0:0] SAME_PORT_RDW = RDW_NEW_DATA;

endpackage : bram_pkg
`default_nettype wire

// File: rtl/bram_init_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bram_init_ctrl
// Description : Post-reset init sweep controller. Walks a counter over
//               0..DEPTH-1, one word per cycle, then settles in READY until
//               the next reset.
// Ports       : clock, reset        - clock / async active-high reset
//               init_busy           - high while the sweep runs
//               init_we, init_addr  - sweep write strobe and address
// Revision    : 1.0 - initial release
// ============================================================================
module bram_init_ctrl
    import bram_pkg::*;
#(
    parameter int ADDR_W        = 5,
    parameter int DEPTH         = 32,
    parameter int INIT_ON_RESET = 1
) (
    input  logic              clock,
    input  logic              reset,
    output logic              init_busy,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    bram_state_t       state, state_next;
    logic [ADDR_W-1:0] cnt, cnt_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        init_we    = 1'b0;
        case (state)
            ST_INIT: begin
                init_we = 1'b1;
                // Stop on the last word so the counter never runs past DEPTH-1.
                if (cnt == LAST_ADDR) begin
                    state_next = ST_READY;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_READY: begin
                state_next = ST_READY;
            end
            default: begin
                state_next = ST_READY;
            end
        endcase
    end

    assign init_busy = (state == ST_INIT);
    assign init_addr = cnt;

endmodule : bram_init_ctrl
`default_nettype wire

// File: rtl/bram_tdp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bram_tdp_ctrl
// Description : Parametrised true dual-port RAM with registered reads and a
//               read-valid strobe per port, deterministic collision policy
//               (A wins on write/write, old data on cross-port read,
//               write-first on same-port read) and a post-reset clear sweep.
// Ports       : clock, reset                  - clock / async active-high reset
//               init_busy                     - sweep in progress, ports ignored
//               data_x, address_x, wren_x,
//               rden_x                        - port x request (x = a, b)
//               q_x, qvalid_x                 - port x read data and strobe
//               collision                     - only with BRAM_COLLISION_DET_EN
// Options     : BRAM_COLLISION_DET_EN adds the registered collision pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_tdp_ctrl
    import bram_pkg::*;
#(
    parameter int                DATA_W        = 16,
    parameter int                ADDR_W        = 5,
    parameter int                DEPTH         = 32,
    parameter int                INIT_ON_RESET = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE    = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              init_busy,
`ifdef BRAM_COLLISION_DET_EN
    output logic              collision,
`endif
    input  logic [DATA_W-1:0] data_a,
    input  logic [ADDR_W-1:0] address_a,
    input  logic              wren_a,
    input  logic              rden_a,
    output logic [DATA_W-1:0] q_a,
    output logic              qvalid_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic [ADDR_W-1:0] address_b,
    input  logic              wren_b,
    input  logic              rden_b,
    output logic [DATA_W-1:0] q_b,
    output logic              qvalid_b
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic              ready;
    logic              in_range_a, in_range_b;
    logic              we_a, we_b;
    logic              same_addr;
    logic [DATA_W-1:0] rd_a, rd_b;

    bram_init_ctrl #(
        .ADDR_W        (ADDR_W),
        .DEPTH         (DEPTH),
        .INIT_ON_RESET (INIT_ON_RESET)
    ) u_init_ctrl (
        .clock     (clock),
        .reset     (reset),
        .init_busy (init_busy),
        .init_we   (init_we),
        .init_addr (init_addr)
    );

    assign ready = ~init_busy;

    // With a fully populated address space every address is legal; the
    // comparison only exists when part of the space is unbacked.
    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_full_range
            assign in_range_a = 1'b1;
            assign in_range_b = 1'b1;
        end else begin : g_partial_range
            assign in_range_a = (32'(address_a) < DEPTH);
            assign in_range_b = (32'(address_b) < DEPTH);
        end
    endgenerate

    assign same_addr = (address_a == address_b);
    assign we_a      = ready & wren_a & in_range_a;
    assign we_b      = ready & wren_b & in_range_b & ~(PORT_A_WINS & we_a & same_addr);

    // The sweep and port writes never overlap: port writes are gated by ready.
    always_ff @(posedge clock) begin
        if (init_we) begin
            mem[init_addr] <= INIT_VALUE;
        end else begin
            if (we_b) mem[address_b] <= data_b;
            if (we_a) mem[address_a] <= data_a;
        end
    end

    // Memory is read before this cycle's writes land, giving old data to
    // the opposite port; a port's own write is bypassed for write-first.
    always_comb begin
        rd_a = mem[address_a];
        rd_b = mem[address_b];
        if (!in_range_a) begin
            rd_a = '0;
        end else if (wren_a && (SAME_PORT_RDW != RDW_OLD_DATA)) begin
            rd_a = data_a;
        end
        if (!in_range_b) begin
            rd_b = '0;
        end else if (wren_b && (SAME_PORT_RDW != RDW_OLD_DATA)) begin
            rd_b = data_b;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_a      <= '0;
            qvalid_a <= 1'b0;
            q_b      <= '0;
            qvalid_b <= 1'b0;
        end else begin
            qvalid_a <= ready & rden_a;
            qvalid_b <= ready & rden_b;
            if (ready && rden_a) q_a <= rd_a;
            if (ready && rden_b) q_b <= rd_b;
        end
    end

`ifdef BRAM_COLLISION_DET_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            collision <= 1'b0;
        end else begin
            collision <= ready & same_addr & (wren_a | wren_b);
        end
    end
`endif

endmodule : bram_tdp_ctrl
`default_nettype wire

// File: tb/tb_bram_tdp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_tdp_ctrl
// Description : Self-checking bench for bram_tdp_ctrl (16x32 default build).
//               A word-array reference model tracks contents and expected
//               outputs; a negedge process compares every cycle, and directed
//               literal checks pin the model on the headline scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_tdp_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          init_busy;
    logic [DW-1:0] data_a = '0, data_b = '0;
    logic [AW-1:0] address_a = '0, address_b = '0;
    logic          wren_a = 1'b0, rden_a = 1'b0, wren_b = 1'b0, rden_b = 1'b0;
    logic [DW-1:0] q_a, q_b;
    logic          qvalid_a, qvalid_b;
`ifdef BRAM_COLLISION_DET_EN
    logic          collision;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    bram_tdp_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .INIT_ON_RESET(1), .INIT_VALUE('0)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .init_busy (init_busy),
`ifdef BRAM_COLLISION_DET_EN
        .collision (collision),
`endif
        .data_a    (data_a),
        .address_a (address_a),
        .wren_a    (wren_a),
        .rden_a    (rden_a),
        .q_a       (q_a),
        .qvalid_a  (qvalid_a),
        .data_b    (data_b),
        .address_b (address_b),
        .wren_b    (wren_b),
        .rden_b    (rden_b),
        .q_b       (q_b),
        .qvalid_b  (qvalid_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] mdl [DEPTH];
    bit            m_valid = 1'b0;
    bit            e_busy;
    int            e_left;
    logic [DW-1:0] e_qa, e_qb;
    bit            e_qva, e_qvb, e_coll;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_valid = 1'b1;
            e_busy  = 1'b1;
            e_left  = DEPTH;
            e_qa    = '0;  e_qb  = '0;
            e_qva   = 1'b0; e_qvb = 1'b0; e_coll = 1'b0;
        end else if (m_valid) begin
            if (e_busy) begin
                e_qva  = 1'b0;
                e_qvb  = 1'b0;
                e_coll = 1'b0;
                e_left = e_left - 1;
                if (e_left == 0) begin
                    e_busy = 1'b0;
                    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
                end
            end else begin
                e_qva  = rden_a;
                e_qvb  = rden_b;
                e_coll = (address_a == address_b) && (wren_a || wren_b);
                if (rden_a) e_qa = wren_a ? data_a : mdl[address_a];
                if (rden_b) e_qb = wren_b ? data_b : mdl[address_b];
                if (wren_b && !(wren_a && address_a == address_b)) mdl[address_b] = data_b;
                if (wren_a) mdl[address_a] = data_a;
            end
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            check("init_busy", 32'(init_busy), 32'(e_busy));
            check("qvalid_a",  32'(qvalid_a),  32'(e_qva));
            check("qvalid_b",  32'(qvalid_b),  32'(e_qvb));
            check("q_a",       32'(q_a),       32'(e_qa));
            check("q_b",       32'(q_b),       32'(e_qb));
`ifdef BRAM_COLLISION_DET_EN
            check("collision", 32'(collision), 32'(e_coll));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic idle();
        wren_a = 1'b0; rden_a = 1'b0; wren_b = 1'b0; rden_b = 1'b0;
    endtask

    task automatic count_sweep(input string name);
        int n;
        bit seen_qv;
        n = 0;
        seen_qv = 1'b0;
        while (init_busy && n < 100) begin
            tick();
            n++;
            if (init_busy && (qvalid_a || qvalid_b)) seen_qv = 1'b1;
        end
        check(name, 32'(n), 32'd32);
        check({name, "_no_qvalid"}, 32'(seen_qv), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #2;
        check("reset_q_a", 32'(q_a), 32'd0);
        check("reset_qvalid_a", 32'(qvalid_a), 32'd0);
        check("reset_busy", 32'(init_busy), 32'd1);
        reset = 1'b0;
        count_sweep("sweep_len");

        // Every word cleared; A reads ascending, B descending.
        for (int i = 0; i < DEPTH; i++) begin
            rden_a = 1'b1; address_a = AW'(i);
            rden_b = 1'b1; address_b = AW'(DEPTH - 1 - i);
            tick();
            check("clear_q_a", 32'(q_a), 32'h0);
            check("clear_qv_a", 32'(qvalid_a), 32'd1);
        end
        idle();

        // Write then read back, then hold.
        wren_a = 1'b1; address_a = 5'd3; data_a = 16'hBEEF; tick(); idle();
        rden_a = 1'b1; tick(); idle();
        check("beef_q", 32'(q_a), 32'hBEEF);
        check("beef_qv", 32'(qvalid_a), 32'd1);
        tick();
        check("beef_hold_q", 32'(q_a), 32'hBEEF);
        check("beef_hold_qv", 32'(qvalid_a), 32'd0);

        // Cross-port read during write returns the old word.
        wren_a = 1'b1; address_a = 5'd7; data_a = 16'hBEEF; tick(); idle();
        wren_a = 1'b1; address_a = 5'd7; data_a = 16'h1234;
        rden_b = 1'b1; address_b = 5'd7; tick(); idle();
        check("xport_old", 32'(q_b), 32'hBEEF);
        rden_b = 1'b1; tick(); idle();
        check("xport_new", 32'(q_b), 32'h1234);

        // Write/write on the same address: A wins.
        wren_a = 1'b1; address_a = 5'd9; data_a = 16'hAAAA;
        wren_b = 1'b1; address_b = 5'd9; data_b = 16'h5555; tick(); idle();
`ifdef BRAM_COLLISION_DET_EN
        check("coll_pulse", 32'(collision), 32'd1);
`endif
        rden_b = 1'b1; address_b = 5'd9; tick(); idle();
`ifdef BRAM_COLLISION_DET_EN
        check("coll_clear", 32'(collision), 32'd0);
`endif
        check("a_wins", 32'(q_b), 32'hAAAA);

        // Same-port write-first.
        wren_a = 1'b1; rden_a = 1'b1; address_a = 5'd2; data_a = 16'h0F0F; tick(); idle();
        check("wr_first", 32'(q_a), 32'h0F0F);

        // Randomised traffic, addresses biased to a small window for collisions.
        for (int c = 0; c < 400; c++) begin
            wren_a = 1'($urandom); rden_a = 1'($urandom);
            wren_b = 1'($urandom); rden_b = 1'($urandom);
            address_a = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            address_b = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            data_a = DW'($urandom); data_b = DW'($urandom);
            tick();
        end
        idle();

        // Reset mid-sweep, then a full sweep with reads requested throughout.
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        repeat (15) tick();
        reset = 1'b1; tick(); tick();
        rden_a = 1'b1; rden_b = 1'b1;
        reset = 1'b0;
        count_sweep("resweep_len");
        idle();
        tick();
        rden_a = 1'b1; address_a = 5'd9; tick(); idle();
        check("resweep_clear", 32'(q_a), 32'h0);
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_bram_tdp_ctrl
`default_nettype wire
